// File: rtl/conv_loop_scheduler.sv
// conv_loop_scheduler: sequences the convolution loop nest (y, x, co, ky, kx, ci).
// It consumes paired activation/weight operands and drives the MAC step/clear controls.
// Each finished accumulation is tagged with its output position and channel.
// Optional stall counter: define CONV_SCHED_STALL_CNT_EN to add the stall_cycles port.
module conv_loop_scheduler #(
   parameter int unsigned FEATURE_MAP_WIDTH  = 128,
   parameter int unsigned FEATURE_MAP_HEIGHT = 128,
   parameter int unsigned INPUT_NB_CHANNELS  = 2,
   parameter int unsigned OUTPUT_NB_CHANNELS = 16,
   parameter int unsigned KERNEL_SIZE        = 3,
   localparam int unsigned XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
   localparam int unsigned YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
   localparam int unsigned CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
   localparam int unsigned COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
   localparam int unsigned KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1
) (
   input  logic           clk,
   input  logic           rst_in,
   input  logic           start,
   output logic           running,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic           b_valid,
   output logic           b_ready,
   output logic [XW-1:0]  cur_x,
   output logic [YW-1:0]  cur_y,
   output logic [COW-1:0] cur_co,
   output logic [CIW-1:0] cur_ci,
   output logic [KW-1:0]  cur_kx,
   output logic [KW-1:0]  cur_ky,
   output logic           mac_step,
   output logic           mac_clear,
`ifdef CONV_SCHED_STALL_CNT_EN
   output logic [31:0]    stall_cycles,
`endif
   output logic           output_valid,
   output logic [XW-1:0]  output_x,
   output logic [YW-1:0]  output_y,
   output logic [COW-1:0] output_ch
);

   localparam logic [XW-1:0]  X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
   localparam logic [YW-1:0]  Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
   localparam logic [CIW-1:0] CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
   localparam logic [COW-1:0] CO_MAX = COW'(OUTPUT_NB_CHANNELS - 1);
   localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [COW-1:0] co_q, co_d;
   logic [CIW-1:0] ci_q, ci_d;
   logic [KW-1:0]  kx_q, kx_d;
   logic [KW-1:0]  ky_q, ky_d;
   logic           ovalid_q, ovalid_d;
   logic [XW-1:0]  otag_x_q, otag_x_d;
   logic [YW-1:0]  otag_y_q, otag_y_d;
   logic [COW-1:0] otag_co_q, otag_co_d;

   logic step_c;
   logic ci_last_c, kx_last_c, ky_last_c, co_last_c, x_last_c, y_last_c;
   logic last_tap_c, final_step_c;

   // Handshake: both operand streams are consumed together only while running
   always_comb begin
      step_c       = (state_q == S_RUN) && a_valid && b_valid;
      ci_last_c    = (ci_q == CI_MAX);
      kx_last_c    = (kx_q == K_MAX);
      ky_last_c    = (ky_q == K_MAX);
      co_last_c    = (co_q == CO_MAX);
      x_last_c     = (x_q  == X_MAX);
      y_last_c     = (y_q  == Y_MAX);
      last_tap_c   = ci_last_c && kx_last_c && ky_last_c;
      final_step_c = last_tap_c && co_last_c && x_last_c && y_last_c;
   end

   // Next-state: FSM, loop counter carry chain and output tagging
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      co_d      = co_q;
      ci_d      = ci_q;
      kx_d      = kx_q;
      ky_d      = ky_q;
      ovalid_d  = 1'b0;
      otag_x_d  = otag_x_q;
      otag_y_d  = otag_y_q;
      otag_co_d = otag_co_q;

      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (step_c && final_step_c) state_d = S_FLUSH;
         S_FLUSH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (step_c) begin
         // innermost first: ci, kx, ky, co, x, y; the final step wraps all to 0
         if (!ci_last_c) begin
            ci_d = ci_q + CIW'(1);
         end else begin
            ci_d = '0;
            if (!kx_last_c) begin
               kx_d = kx_q + KW'(1);
            end else begin
               kx_d = '0;
               if (!ky_last_c) begin
                  ky_d = ky_q + KW'(1);
               end else begin
                  ky_d = '0;
                  if (!co_last_c) begin
                     co_d = co_q + COW'(1);
                  end else begin
                     co_d = '0;
                     if (!x_last_c) begin
                        x_d = x_q + XW'(1);
                     end else begin
                        x_d = '0;
                        if (!y_last_c) y_d = y_q + YW'(1);
                        else           y_d = '0;
                     end
                  end
               end
            end
         end

         if (last_tap_c) begin
            ovalid_d  = 1'b1;
            otag_x_d  = x_q;
            otag_y_d  = y_q;
            otag_co_d = co_q;
         end
      end
   end

   // State, counter and output-tag registers
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         co_q      <= '0;
         ci_q      <= '0;
         kx_q      <= '0;
         ky_q      <= '0;
         ovalid_q  <= 1'b0;
         otag_x_q  <= '0;
         otag_y_q  <= '0;
         otag_co_q <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         co_q      <= co_d;
         ci_q      <= ci_d;
         kx_q      <= kx_d;
         ky_q      <= ky_d;
         ovalid_q  <= ovalid_d;
         otag_x_q  <= otag_x_d;
         otag_y_q  <= otag_y_d;
         otag_co_q <= otag_co_d;
      end
   end

`ifdef CONV_SCHED_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   // Stall counter: RUN cycles without a step, saturating, restarted by an accepted start
   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && start) begin
         stall_d = '0;
      end else if ((state_q == S_RUN) && !step_c && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst_in) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

   assign running      = (state_q != S_IDLE);
   assign a_ready      = step_c;
   assign b_ready      = step_c;
   assign mac_step     = step_c;
   assign mac_clear    = step_c && (ci_q == '0) && (kx_q == '0) && (ky_q == '0);
   assign cur_x        = x_q;
   assign cur_y        = y_q;
   assign cur_co       = co_q;
   assign cur_ci       = ci_q;
   assign cur_kx       = kx_q;
   assign cur_ky       = ky_q;
   assign output_valid = ovalid_q;
   assign output_x     = otag_x_q;
   assign output_y     = otag_y_q;
   assign output_ch    = otag_co_q;

endmodule
